// File: rtl/irq_controller.sv
// irq_controller: memory-mapped, fixed-priority interrupt controller for N_IRQ channels.
//
// It sits on the data-memory/IO bus and owns the interrupt/intVect/intAck handshake to the CPU.
// Each channel has an enable bit, a level or rising-edge sensing mode and a pending bit.
// Channel 0 has the highest priority.
//
// Register map, byte offsets from BASE_ADDR:
//   0/1 EN_L/EN_H      per-channel enable
//   2/3 PEND_L/PEND_H  pending; writing 1 clears edge-mode channels only
//   4/5 EDGE_L/EDGE_H  1 = rising-edge mode, 0 = level mode
//   6   CTRL           bit0 = GIE
//   7   STATUS         read: bit7 = a channel is in service, bits3:0 = its index; any write = EOI
//
// Ports:
//   clk, rst         single clock; synchronous active-high reset
//   address, din     bus address and write data
//   w_en, r_en       write and read strobes
//   dout             read data, registered; holds until the next read
//   irq_in           peripheral request lines
//   interrupt        request to the CPU
//   intVect          vector of the current request
//   intAck           one-cycle acknowledge from the CPU
//
// Optional feature, enabled by defining IRQ_NESTING_EN: a higher-priority candidate preempts the
// channel in service, and in-service channels are tracked as a bitmask stack. In the default
// build, at most one channel is in service at any time.
module irq_controller #(
    parameter int unsigned N_IRQ       = 8,
    parameter logic [15:0] BASE_ADDR   = 16'h00F0,
    parameter logic [15:0] VECT_BASE   = 16'h0002,
    parameter int unsigned VECT_STRIDE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      address,
    input  logic [7:0]       din,
    input  logic             w_en,
    input  logic             r_en,
    output logic [7:0]       dout,
    input  logic [N_IRQ-1:0] irq_in,
    output logic             interrupt,
    output logic [15:0]      intVect,
    input  logic             intAck
);

    // Channels are handled internally as 16-bit vectors. Bits at or above N_IRQ are forced to 0.
    localparam logic [15:0] ValidMask =
        (N_IRQ >= 16) ? 16'hFFFF : 16'((32'd1 << N_IRQ) - 32'd1);

    typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

    state_e      state_q, state_d;
    logic [15:0] en_q, en_d;
    logic [15:0] pend_q, pend_d;
    logic [15:0] edge_q, edge_d;
    logic [15:0] prev_q;
    logic        gie_q, gie_d;
    logic [3:0]  idx_q, idx_d;
    logic        int_q, int_d;
    logic [15:0] vect_q, vect_d;
    logic [7:0]  dout_q, dout_d;

`ifdef IRQ_NESTING_EN
    logic [15:0] in_svc_q, in_svc_d;
    logic [15:0] svc_low_oh;
    logic [15:0] svc_below;
    logic        preempt;
`else
    logic        in_svc_q, in_svc_d;
`endif

    logic [15:0] offset;
    logic        in_range;
    logic [2:0]  reg_sel;
    logic        wr;
    logic [15:0] irq_ext;
    logic [15:0] w1c;
    logic        eoi;
    logic [15:0] ack_clr;
    logic [15:0] cand;
    logic        cand_any;
    logic [3:0]  cand_idx;
    logic [31:0] vect_calc;
    logic        svc_busy;
    logic [3:0]  svc_idx;
    logic [7:0]  rdata;

    // Bus decode. Subtracting first keeps the range check correct near the top of the space.
    assign offset   = address - BASE_ADDR;
    assign in_range = (offset[15:3] == 13'd0);
    assign reg_sel  = offset[2:0];
    assign wr       = w_en & in_range;

    always_comb begin
        irq_ext = '0;
        irq_ext[N_IRQ-1:0] = irq_in;
    end

    // Candidate selection: lowest set index wins.
    assign cand = pend_q & en_q & {16{gie_q}};

    always_comb begin
        cand_any = 1'b0;
        cand_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (cand[i]) begin
                cand_any = 1'b1;
                cand_idx = 4'(i);
            end
        end
    end

    assign vect_calc = 32'(VECT_BASE) + 32'(cand_idx) * VECT_STRIDE;

`ifdef IRQ_NESTING_EN
    // Lowest set bit of the in-service stack is the channel currently being served.
    assign svc_low_oh = in_svc_q & (~in_svc_q + 16'd1);
    assign svc_below  = (in_svc_q == 16'd0) ? 16'hFFFF : (svc_low_oh - 16'd1);
    assign preempt    = |(cand & svc_below);
    assign svc_busy   = |in_svc_q;

    always_comb begin
        svc_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (in_svc_q[i]) begin
                svc_idx = 4'(i);
            end
        end
    end
`else
    assign svc_busy = in_svc_q;
    assign svc_idx  = idx_q;
`endif

    // Register writes.
    always_comb begin
        en_d   = en_q;
        edge_d = edge_q;
        gie_d  = gie_q;
        w1c    = '0;
        eoi    = 1'b0;
        if (wr) begin
            unique case (reg_sel)
                3'd0: en_d[7:0]    = din;
                3'd1: en_d[15:8]   = din;
                3'd2: w1c[7:0]     = din;
                3'd3: w1c[15:8]    = din;
                3'd4: edge_d[7:0]  = din;
                3'd5: edge_d[15:8] = din;
                3'd6: gie_d        = din[0];
                3'd7: eoi          = 1'b1;
                default: ;
            endcase
        end
        en_d   = en_d & ValidMask;
        edge_d = edge_d & ValidMask;
    end

    // Read mux. The value is taken from the current state, so a same-cycle write is not visible.
    always_comb begin
        rdata = 8'h00;
        unique case (reg_sel)
            3'd0: rdata = en_q[7:0];
            3'd1: rdata = en_q[15:8];
            3'd2: rdata = pend_q[7:0];
            3'd3: rdata = pend_q[15:8];
            3'd4: rdata = edge_q[7:0];
            3'd5: rdata = edge_q[15:8];
            3'd6: rdata = {7'd0, gie_q};
            3'd7: rdata = {svc_busy, 3'd0, svc_busy ? svc_idx : 4'd0};
            default: ;
        endcase
    end

    always_comb begin
        dout_d = dout_q;
        if (r_en) begin
            dout_d = in_range ? rdata : 8'h00;
        end
    end

    // Handshake FSM.
    always_comb begin
        state_d  = state_q;
        int_d    = int_q;
        vect_d   = vect_q;
        idx_d    = idx_q;
        in_svc_d = in_svc_q;
        ack_clr  = '0;
        unique case (state_q)
            StIdle: begin
                if (cand_any) begin
                    idx_d   = cand_idx;
                    vect_d  = vect_calc[15:0];
                    int_d   = 1'b1;
                    state_d = StReq;
                end
            end
            StReq: begin
                // Once raised, a request is held until it is acknowledged.
                if (intAck) begin
                    int_d   = 1'b0;
                    ack_clr = edge_q & (16'd1 << idx_q);
`ifdef IRQ_NESTING_EN
                    in_svc_d = in_svc_q | (16'd1 << idx_q);
`else
                    in_svc_d = 1'b1;
`endif
                    state_d = StService;
                end
            end
            StService: begin
`ifdef IRQ_NESTING_EN
                if (eoi) begin
                    in_svc_d = in_svc_q & ~svc_low_oh;
                    if ((in_svc_q & ~svc_low_oh) == 16'd0) begin
                        state_d = StIdle;
                    end
                end else if (preempt) begin
                    idx_d   = cand_idx;
                    vect_d  = vect_calc[15:0];
                    int_d   = 1'b1;
                    state_d = StReq;
                end
`else
                if (eoi) begin
                    in_svc_d = 1'b0;
                    state_d  = StIdle;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    // Pending update. In edge mode a new rising edge beats any clear in the same cycle.
    // In level mode the pending bit simply follows the registered input.
    always_comb begin
        logic [15:0] clr;
        logic [15:0] rise;
        clr    = (w1c | ack_clr) & edge_q;
        rise   = irq_ext & ~prev_q;
        pend_d = ValidMask & ((edge_q & ((pend_q & ~clr) | rise)) | (~edge_q & irq_ext));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            en_q     <= '0;
            pend_q   <= '0;
            edge_q   <= '0;
            prev_q   <= '0;
            gie_q    <= 1'b0;
            idx_q    <= '0;
            int_q    <= 1'b0;
            vect_q   <= '0;
            dout_q   <= '0;
            in_svc_q <= '0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            pend_q   <= pend_d;
            edge_q   <= edge_d;
            prev_q   <= irq_ext & ValidMask;
            gie_q    <= gie_d;
            idx_q    <= idx_d;
            int_q    <= int_d;
            vect_q   <= vect_d;
            dout_q   <= dout_d;
            in_svc_q <= in_svc_d;
        end
    end

    assign dout      = dout_q;
    assign interrupt = int_q;
    assign intVect   = vect_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed testbench for irq_controller with default parameters (8 channels, base address 0x00F0).
// Inputs are driven and outputs are sampled on the falling clock edge.
module tb_irq_controller;

    localparam logic [15:0] EnL    = 16'h00F0;
    localparam logic [15:0] EnH    = 16'h00F1;
    localparam logic [15:0] PendL  = 16'h00F2;
    localparam logic [15:0] EdgeL  = 16'h00F4;
    localparam logic [15:0] Ctrl   = 16'h00F6;
    localparam logic [15:0] Status = 16'h00F7;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] address;
    logic [7:0]  din;
    logic        w_en;
    logic        r_en;
    logic [7:0]  dout;
    logic [7:0]  irq_in;
    logic        interrupt;
    logic [15:0] intVect;
    logic        intAck;

    int n_checks = 0;
    int n_pass   = 0;

    irq_controller dut (
        .clk       (clk),
        .rst       (rst),
        .address   (address),
        .din       (din),
        .w_en      (w_en),
        .r_en      (r_en),
        .dout      (dout),
        .irq_in    (irq_in),
        .interrupt (interrupt),
        .intVect   (intVect),
        .intAck    (intAck)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr_reg(input logic [15:0] a, input logic [7:0] d);
        address = a;
        din     = d;
        w_en    = 1'b1;
        tick();
        w_en    = 1'b0;
    endtask

    task automatic rd_reg(input logic [15:0] a, output logic [7:0] d);
        address = a;
        r_en    = 1'b1;
        tick();
        r_en    = 1'b0;
        d       = dout;
    endtask

    task automatic ack();
        intAck = 1'b1;
        tick();
        intAck = 1'b0;
    endtask

    initial begin
        logic [7:0] rd;
        rst     = 1'b1;
        address = 16'h0000;
        din     = 8'h00;
        w_en    = 1'b0;
        r_en    = 1'b0;
        irq_in  = 8'h00;
        intAck  = 1'b0;
        repeat (2) tick();
        check("rst_interrupt", 16'(interrupt), 16'h0000);
        check("rst_vect", intVect, 16'h0000);
        check("rst_dout", 16'(dout), 16'h0000);
        rst = 1'b0;
        rd_reg(Status, rd);
        check("rst_status", 16'(rd), 16'h0000);

        // Edge channel 2: two-cycle latency, then ack clears pending.
        wr_reg(EnL, 8'h04);
        wr_reg(EdgeL, 8'h04);
        wr_reg(Ctrl, 8'h01);
        irq_in = 8'h04;
        tick();
        check("t1_not_yet", 16'(interrupt), 16'h0000);
        irq_in = 8'h00;
        tick();
        check("t1_interrupt", 16'(interrupt), 16'h0001);
        check("t1_vect", intVect, 16'h0006);
        ack();
        check("t1_ack_drop", 16'(interrupt), 16'h0000);
        rd_reg(PendL, rd);
        check("t1_pend_clr", 16'(rd), 16'h0000);
        rd_reg(Status, rd);
        check("t1_status", 16'(rd), 16'h0082);
        wr_reg(Status, 8'h00);
        tick();
        check("t1_idle", 16'(interrupt), 16'h0000);

        // Level channels 1 and 5 raised together.
        wr_reg(EdgeL, 8'h00);
        wr_reg(EnL, 8'h22);
        irq_in = 8'h22;
        tick();
        tick();
        check("t2_int", 16'(interrupt), 16'h0001);
        check("t2_vect_ch1", intVect, 16'h0004);
        ack();
        wr_reg(Status, 8'h00);
        check("t2_eoi_gap", 16'(interrupt), 16'h0000);
        tick();
        check("t2_rereq", 16'(interrupt), 16'h0001);
        check("t2_rereq_vect", intVect, 16'h0004);
        ack();
        irq_in = 8'h20;
        tick();
        wr_reg(Status, 8'h00);
        tick();
        check("t2_ch5_int", 16'(interrupt), 16'h0001);
        check("t2_ch5_vect", intVect, 16'h000C);

        // Request is held even when its enable is cleared before the ack.
        wr_reg(EnL, 8'h00);
        tick();
        tick();
        check("t3_held", 16'(interrupt), 16'h0001);
        check("t3_vect", intVect, 16'h000C);
        ack();
        check("t3_ack", 16'(interrupt), 16'h0000);
        irq_in = 8'h00;
        tick();
        wr_reg(Status, 8'h00);
        tick();
        check("t3_idle", 16'(interrupt), 16'h0000);

        // Edge on channel 3 colliding with a W1C of the same bit: set wins.
        wr_reg(EdgeL, 8'h08);
        irq_in  = 8'h08;
        address = PendL;
        din     = 8'h08;
        w_en    = 1'b1;
        tick();
        w_en    = 1'b0;
        rd_reg(PendL, rd);
        check("t4_set_wins", 16'(rd), 16'h0008);
        wr_reg(PendL, 8'h08);
        rd_reg(PendL, rd);
        check("t4_w1c", 16'(rd), 16'h0000);
        irq_in = 8'h02;
        tick();
        wr_reg(PendL, 8'h02);
        rd_reg(PendL, rd);
        check("t4_level_no_w1c", 16'(rd), 16'h0002);
        irq_in = 8'h00;
        wr_reg(EnH, 8'hFF);
        rd_reg(EnH, rd);
        check("t4_en_h_zero", 16'(rd), 16'h0000);
        rd_reg(Ctrl, rd);
        check("t4_ctrl", 16'(rd), 16'h0001);
        tick();
        tick();
        check("t4_dout_hold", 16'(dout), 16'h0001);
        rd_reg(16'h00F8, rd);
        check("t4_out_of_range", 16'(rd), 16'h0000);

        // Channel 4 in service, then channel 0 arrives.
        wr_reg(EdgeL, 8'h11);
        wr_reg(EnL, 8'h11);
        irq_in = 8'h10;
        tick();
        irq_in = 8'h00;
        tick();
        check("t5_ch4_int", 16'(interrupt), 16'h0001);
        check("t5_ch4_vect", intVect, 16'h000A);
        ack();
        rd_reg(Status, rd);
        check("t5_status_ch4", 16'(rd), 16'h0084);
        irq_in = 8'h01;
        tick();
        irq_in = 8'h00;
        tick();
`ifdef IRQ_NESTING_EN
        check("t5_preempt", 16'(interrupt), 16'h0001);
        check("t5_preempt_vect", intVect, 16'h0002);
        ack();
        rd_reg(Status, rd);
        check("t5_status_ch0", 16'(rd), 16'h0080);
        wr_reg(Status, 8'h00);
        rd_reg(Status, rd);
        check("t5_status_pop", 16'(rd), 16'h0084);
        wr_reg(Status, 8'h00);
        tick();
        check("t5_idle", 16'(interrupt), 16'h0000);
        rd_reg(Status, rd);
        check("t5_status_idle", 16'(rd), 16'h0000);
`else
        check("t5_no_preempt", 16'(interrupt), 16'h0000);
        tick();
        check("t5_still_waiting", 16'(interrupt), 16'h0000);
        wr_reg(Status, 8'h00);
        check("t5_eoi_gap", 16'(interrupt), 16'h0000);
        tick();
        check("t5_ch0_int", 16'(interrupt), 16'h0001);
        check("t5_ch0_vect", intVect, 16'h0002);
        ack();
        rd_reg(Status, rd);
        check("t5_status_ch0", 16'(rd), 16'h0080);
        wr_reg(Status, 8'h00);
        tick();
        check("t5_idle", 16'(interrupt), 16'h0000);
`endif

        // Reset in the middle of a request; a late ack is ignored.
        irq_in = 8'h10;
        tick();
        irq_in = 8'h00;
        tick();
        check("t6_req", 16'(interrupt), 16'h0001);
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        intAck = 1'b1;
        check("t6_rst_int", 16'(interrupt), 16'h0000);
        check("t6_rst_vect", intVect, 16'h0000);
        check("t6_rst_dout", 16'(dout), 16'h0000);
        tick();
        intAck = 1'b0;
        check("t6_late_ack", 16'(interrupt), 16'h0000);
        rd_reg(EnL, rd);
        check("t6_en", 16'(rd), 16'h0000);
        rd_reg(EdgeL, rd);
        check("t6_edge", 16'(rd), 16'h0000);
        rd_reg(Ctrl, rd);
        check("t6_ctrl", 16'(rd), 16'h0000);
        rd_reg(PendL, rd);
        check("t6_pend", 16'(rd), 16'h0000);
        rd_reg(Status, rd);
        check("t6_status", 16'(rd), 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
